// File: rtl/seven_seg_scanner_if.sv
// Producer-side handshake bundle for the seven-segment scanner.
// The producer drives a 32-bit hex word and eight decimal-point bits under
// data_valid. The scanner accepts them while data_ready is high.
interface seven_seg_scanner_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  dp_in;

  modport master (output data_in, output data_valid, output dp_in, input data_ready);
  modport slave  (input data_in, input data_valid, input dp_in, output data_ready);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan stage for an 8-digit seven-segment display.
// - A new hex word is accepted into a pending buffer.
// - The word moves into the display register only at a frame boundary
//   (slot 7 -> slot 0), so a frame never shows two different values.
// - One anode is driven low per refresh slot, or none when the slot is blanked.
// - Cathodes, dp and anodes are all active-low and registered.
// Optional build macro SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  seven_seg_scanner_if.slave bus,
  input  logic [7:0]         digit_en,
  output logic [7:0]         anode,
  output logic [6:0]         cathode,
  output logic               dp,
  output logic               digit_strobe,
  output logic               frame_done
);

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  // Digit 0 and digits with a lit decimal point are always kept.
  function automatic logic lz_blank(input logic [31:0] val, input logic [7:0] dpv,
                                    input logic [2:0] i);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(i) && val[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return (i != 3'd0) && !dpv[i] && upper_zero;
  endfunction
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [7:0]       disp_dp_q, disp_dp_d;
  logic [31:0]      pend_q, pend_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       cathode_q, cathode_d;
  logic             dp_q, dp_d;
  logic             strobe_q, strobe_d;
  logic             frame_q, frame_d;

  logic             tc;
  logic             frame_end;
  logic             show;
  logic [3:0]       cur_nib;

  // Next-state logic: prescaler, slot index, buffers and output decode
  always_comb begin
    tc        = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end = tc && (idx_q == 3'd7);

    cnt_d    = tc ? '0 : cnt_q + CNT_W'(1);
    idx_d    = tc ? idx_q + 3'd1 : idx_q;
    strobe_d = tc;
    frame_d  = frame_end;

    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;

    // Capture only while the buffer is empty. Hand over only while it is full.
    // The two conditions are mutually exclusive.
    if (bus.data_valid && !pend_full_q) begin
      pend_d      = bus.data_in;
      pend_dp_d   = bus.dp_in;
      pend_full_d = 1'b1;
    end else if (frame_end && pend_full_q) begin
      disp_d      = pend_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end

    cur_nib = disp_q[{idx_q, 2'b00} +: 4];
    show    = digit_en[idx_q];
`ifdef SEG_LZB_EN
    if (lz_blank(disp_q, disp_dp_q, idx_q)) show = 1'b0;
`endif

    anode_d   = show ? ~(8'b1 << idx_q) : 8'hFF;
    cathode_d = show ? hex7seg(cur_nib) : 7'h7F;
    dp_d      = show ? ~disp_dp_q[idx_q] : 1'b1;
  end

  // State and registered outputs, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      disp_q      <= 32'd0;
      disp_dp_q   <= 8'd0;
      pend_q      <= 32'd0;
      pend_dp_q   <= 8'd0;
      pend_full_q <= 1'b0;
      anode_q     <= 8'hFF;
      cathode_q   <= 7'h7F;
      dp_q        <= 1'b1;
      strobe_q    <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      dp_q        <= dp_d;
      strobe_q    <= strobe_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.data_ready = ~pend_full_q;
  assign anode          = anode_q;
  assign cathode        = cathode_q;
  assign dp             = dp_q;
  assign digit_strobe   = strobe_q;
  assign frame_done     = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner.
// The reference model works from the count of clock edges since reset:
// - slot = (edges / REFRESH_DIV) mod 8;
// - accepted words are displayed from the frame after they were taken.
module tb_seven_seg_scanner;
  localparam int D  = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] digit_en;
  logic [7:0] anode;
  logic [6:0] cathode;
  logic       dp;
  logic       digit_strobe;
  logic       frame_done;

  seven_seg_scanner_if bus_if();

  seven_seg_scanner #(.REFRESH_DIV(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .digit_en     (digit_en),
    .anode        (anode),
    .cathode      (cathode),
    .dp           (dp),
    .digit_strobe (digit_strobe),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int unsigned m_n;
  bit          m_full;
  logic [31:0] m_pv, m_disp;
  logic [7:0]  m_pdp, m_dp;
  bit          accepted;

  logic [7:0]  exp_anode;
  logic [6:0]  exp_cath;
  logic        exp_dp, exp_strobe, exp_frame, exp_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, m_n);
  endtask

  task automatic model_reset();
    m_n = 0; m_full = 0; m_pv = '0; m_pdp = '0; m_disp = '0; m_dp = '0;
  endtask

  // Expected outputs after the coming edge, then advance the model by one edge
  task automatic model_edge();
    int unsigned slot;
    bit          tc;
    bit          show;
    slot = (m_n / D) % 8;
    tc   = (m_n % D) == D - 1;
    show = digit_en[slot];
`ifdef SEG_LZB_EN
    if (slot != 0 && !m_dp[slot] && (m_disp >> (4 * slot)) == 32'd0) show = 0;
`endif
    exp_anode  = show ? ~(8'd1 << slot) : 8'hFF;
    exp_cath   = show ? seg_tbl[(m_disp >> (4 * slot)) & 32'hF] : 7'h7F;
    exp_dp     = show ? ~m_dp[slot] : 1'b1;
    exp_strobe = tc;
    exp_frame  = tc && slot == 7;
    accepted   = 0;
    if (bus_if.data_valid && !m_full) begin
      m_full = 1; m_pv = bus_if.data_in; m_pdp = bus_if.dp_in; accepted = 1;
    end else if (tc && slot == 7 && m_full) begin
      m_disp = m_pv; m_dp = m_pdp; m_full = 0;
    end
    exp_ready = !m_full;
    m_n++;
  endtask

  task automatic reset_check(input string tag);
    check_eq({tag, "_anode"}, 32'(anode), 32'hFF);
    check_eq({tag, "_cathode"}, 32'(cathode), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_strobe"}, 32'(digit_strobe), 32'h0);
    check_eq({tag, "_frame"}, 32'(frame_done), 32'h0);
    check_eq({tag, "_ready"}, 32'(bus_if.data_ready), 32'h1);
  endtask

  task automatic step();
    logic inv_ok;
    model_edge();
    @(posedge clk);
    #1;
    check_eq("anode", 32'(anode), 32'(exp_anode));
    check_eq("cathode", 32'(cathode), 32'(exp_cath));
    check_eq("dp", 32'(dp), 32'(exp_dp));
    check_eq("digit_strobe", 32'(digit_strobe), 32'(exp_strobe));
    check_eq("frame_done", 32'(frame_done), 32'(exp_frame));
    check_eq("data_ready", 32'(bus_if.data_ready), 32'(exp_ready));
    inv_ok = (anode == 8'hFF) || $onehot(~anode);
    check_eq("anode_onehot", 32'(inv_ok), 32'h1);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 5)
      0:       return 32'h0;
      1:       return 32'h0000_00A5;
      2:       return $urandom & 32'hFF;
      3:       return $urandom & 32'hF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    reset_check("async");
    model_reset();
    @(posedge clk);
    #1;
    reset_check("held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = '0;
    bus_if.dp_in      = '0;
    digit_en          = 8'hFF;
    model_reset();
    #12;
    reset_check("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 9) begin
        bus_if.data_valid = 1'b1;
        bus_if.data_in    = 32'h0123_4567;
        bus_if.dp_in      = 8'h01;
      end else if (c >= 10 && !(bus_if.data_valid && !accepted)) begin
        bus_if.data_valid = (c % 500 == 495) || ($urandom % 3 == 0);
        bus_if.data_in    = rand_word();
        bus_if.dp_in      = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom);
      end
      if (c >= 200 && c % 37 == 0) begin
        case ($urandom % 4)
          0, 1: digit_en = 8'hFF;
          2:    digit_en = 8'hF0;
          default: digit_en = 8'($urandom);
        endcase
      end
      if (c == 1500 || c == 2403) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed scan stage for the 8-digit seven-segment display on the UART TX controller board. Accepts a 32-bit hex value through a valid/ready handshake and double-buffers it so updates land only on frame boundaries, with no tearing. Rotates one active-low anode per refresh slot and drives active-low cathodes and the decimal point. Its anode output feeds the downstream anode decoding stage directly; exactly one bit is low at any time, or all bits are high.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot; legal range >= 2.
CNT_W, 17, prescaler counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
data_in  input  32  hex value; nibble i shown on digit i
data_valid  input  1  data_in valid
data_ready  output  1  pending buffer empty, can accept
dp_in  input  8  decimal point per digit, 1 = lit; captured with data_in
digit_en  input  8  live per-digit enable, 0 = blank that digit
anode  output  8  active-low digit select; digit i -> bit i low
cathode  output  7  active-low segments {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point
digit_strobe  output  1  one-cycle pulse when the digit index advances
frame_done  output  1  one-cycle pulse when the index wraps 7->0

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, idx=0
  - disp_reg=0, disp_dp=0
  - pending empty, data_ready=1
  - anode=8'hFF, cathode=7'h7F, dp=1
  - digit_strobe=0, frame_done=0
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - Terminal count (tc) occurs at REFRESH_DIV-1; on tc, idx <= idx+1 mod 8 and digit_strobe=1 on the next cycle.
  - On tc with idx==7, frame_done=1 on the next cycle.
- Handshake:
  - Capture occurs when data_valid && data_ready. {data_in, dp_in} go to pending_reg, pending becomes full, and data_ready drops the next cycle.
  - data_valid is ignored while data_ready=0; the producer holds its data.
- Frame-boundary transfer:
  - On tc with idx==7 and pending full: disp_reg/disp_dp <= pending, pending becomes empty, data_ready=1 the next cycle.
  - Capture and transfer cannot coincide, because data_ready=0 whenever pending is full.
  - If pending is empty at the boundary, the display is unchanged.
- Outputs (registered, one-cycle latency from idx/disp_reg):
  - anode = ~(8'b1 << idx) when the digit is enabled, else 8'hFF.
  - cathode = hex7seg(disp_reg[4*idx+:4]) when enabled, else 7'h7F.
  - dp = ~disp_dp[idx] when enabled, else 1.
- hex7seg (active-low, gfedcba), 0..F:
  40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Anode invariant: anode is never anything other than one-low or all-high.
- Mid-operation reset: returns immediately to the reset values. Any pending data is lost, and disp_reg clears to 0.
- digit_en is sampled live each cycle, not buffered.

Optional Feature:
SEG_LZB_EN: leading-zero blanking.
- Defined: digit i is also blanked (anode bit high, cathode 7'h7F, dp 1) when all of disp_reg nibbles i..7 are zero, except:
  - digit 0 is never blanked by this rule;
  - a digit whose disp_dp bit is 1 is never blanked by this rule.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
- Reset then release, REFRESH_DIV=4 -> anode=FE, cathode=40 within 1 cycle; digit_strobe every 4 cycles; anode sequence FE,FD,FB,...,7F,FE.
- Load 32'h0123_4567 with dp_in=8'h01 mid-frame -> data_ready low; display stays 0 until the first frame_done, then digit0 cathode=78 with dp=0 and digit7 cathode=40; data_ready returns high.
- Second data_valid held while pending full -> not captured; captured on the first cycle data_ready=1; no value lost or duplicated.
- digit_en=8'hF0 -> anode never drives bits 0..3 low; cathode=7F during those slots.
- Assert rst_n low mid-frame with pending full -> anode=FF, data_ready=1 asynchronously; after release, digits show 0.
- SEG_LZB_EN, value 32'h0000_00A5 -> only digits 0,1 driven (cathode 12, 08); value 0 -> only digit 0 driven (cathode 40).
